// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: a run/lap/pause FSM over a prescaled 3-digit BCD counter.
// The display shows a frozen lap value while in LAP and the live count otherwise.
module stopwatch_ctrl #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic       running,
  output logic       lap_active,
  output logic       step,
  output logic       ovf
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [11:0] COUNT_TOP = 12'h999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [11:0]   count, count_nxt;
  logic [11:0]   lap_reg, lap_nxt;
  logic          ovf_nxt;
  logic          step_nxt;
  logic          counting;
  logic          inc;
  logic [11:0]   shown;

  // Decimal increment of a packed hundreds:tens:ones value; 999 rolls to 000.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      count   <= '0;
      lap_reg <= '0;
      ovf     <= 1'b0;
      step    <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      count   <= count_nxt;
      lap_reg <= lap_nxt;
      ovf     <= ovf_nxt;
      step    <= step_nxt;
    end
  end

  // Timing runs off the state held before the edge, so the edge that leaves
  // RUN/LAP still advances the prescaler and may still increment.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    count_nxt = count;
    lap_nxt   = lap_reg;
    ovf_nxt   = ovf;
    step_nxt  = 1'b0;
    inc       = 1'b0;
    counting  = (state == RUN) || (state == LAP);

    if (counting) begin
      if (presc == PRESC_MAX) begin
        presc_nxt = '0;
        inc       = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end

    if (inc) begin
      count_nxt = bcd_inc(count);
      step_nxt  = 1'b1;
      if (count == COUNT_TOP) begin
        ovf_nxt = 1'b1;
      end
    end

    // Command priority is clr > start_stop > lap; clr only means something in PAUSE.
    case (state)
      IDLE: begin
        if (start_stop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (start_stop) begin
          state_nxt = PAUSE;
        end else if (lap) begin
          state_nxt = LAP;
          lap_nxt   = count;
        end
      end
      LAP: begin
        if (start_stop) begin
          state_nxt = PAUSE;
        end else if (lap) begin
          state_nxt = RUN;
        end
      end
      PAUSE: begin
        if (clr) begin
          state_nxt = IDLE;
          presc_nxt = '0;
          count_nxt = '0;
          lap_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (start_stop) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    shown      = (state == LAP) ? lap_reg : count;
    d0         = shown[3:0];
    d1         = shown[7:4];
    d2         = shown[11:8];
    running    = (state == RUN) || (state == LAP);
    lap_active = (state == LAP);
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 10: clk cycles per count increment; legal range 2..1023.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1: synchronous, active-high reset, sampled on clk rising edge.
REQ-004 Port start_stop  input  1: one-cycle command pulse; toggles run/pause.
REQ-005 Port lap  input  1: one-cycle command pulse; freezes or releases the display.
REQ-006 Port clr  input  1: one-cycle command pulse; clears the count, honoured only in PAUSE.
REQ-007 Port d0, d1, d2  output  4 each: displayed BCD digits (ones, tens, hundreds).
REQ-008 Port running  output  1: high in RUN or LAP.
REQ-009 Port lap_active  output  1: high in LAP.
REQ-010 Port step  output  1: one-cycle pulse on the cycle after each count increment.
REQ-011 Port ovf  output  1: sticky wrap flag.

Function
REQ-012 FSM states SHALL be IDLE, RUN, LAP and PAUSE; state, prescaler, count, lap register and ovf are all registered.
REQ-013 Transitions SHALL be: IDLE-start_stop->RUN; RUN-start_stop->PAUSE; RUN-lap->LAP; LAP-lap->RUN; LAP-start_stop->PAUSE; PAUSE-start_stop->RUN; PAUSE-clr->IDLE; all other inputs hold the current state.
REQ-014 Simultaneous commands SHALL resolve with priority clr > start_stop > lap; lower-priority commands are discarded.
REQ-015 clr outside PAUSE SHALL be ignored.
REQ-016 Prescaler presc (0..DIV-1) SHALL advance on every edge while the current registered state is RUN or LAP, including the edge that leaves that state.
REQ-017 presc SHALL hold its value in PAUSE, so partial intervals are preserved.
REQ-018 presc SHALL be 0 in IDLE.
REQ-019 When presc==DIV-1 and state is RUN or LAP, presc SHALL become 0 and the 3-digit BCD count SHALL increment, with decimal carry ones->tens->hundreds; each digit always stays 0..9.
REQ-020 The first increment SHALL occur on the DIV-th edge after the edge that enters RUN from IDLE.
REQ-021 Count 999 SHALL wrap to 000 and set ovf=1; ovf stays 1 until reset or clr.
REQ-022 step SHALL be a registered pulse, high for exactly one cycle following each increment edge, including the wrap.
REQ-023 On the RUN->LAP edge, the lap register SHALL capture the count value present before that edge.
REQ-024 In LAP, d2:d1:d0 SHALL show the lap register while the internal count keeps running; in all other states they SHALL show the live count.
REQ-025 On LAP->PAUSE, the display SHALL immediately show the live count.
REQ-026 PAUSE-clr->IDLE SHALL zero the count, presc, lap register and ovf on the same edge.

Reset
REQ-027 While reset=1 at an edge: state=IDLE, count=000, presc=0, lap register=000, ovf=0, step=0, running=0, lap_active=0.
REQ-028 reset SHALL override every command and apply mid-operation from any state.
REQ-029 No output SHALL change asynchronously to clk.

Verification
REQ-030 Reset: reset=1 for 2 cycles -> d2:d1:d0=000, running=0, lap_active=0, ovf=0, step=0.
REQ-031 Run (DIV=4): start_stop pulse, then 48 edges -> d=012, exactly 12 step pulses, running=1.
REQ-032 Lap (DIV=4): lap at count 005 -> d holds 005 for 20 further cycles while internal count reaches 010; second lap -> d=010 next cycle, lap_active=0.
REQ-033 Pause/clr (DIV=4): pause with presc=2, hold 50 cycles -> count unchanged; resume -> next increment after 2 edges. clr in RUN -> no effect; clr in PAUSE -> d=000, state IDLE.
REQ-034 Wrap: run from 998 across 2 increments -> d=000, ovf=1, step pulses twice; then pause+clr -> ovf=0.
REQ-035 Conflicts: start_stop+lap together in RUN -> PAUSE, lap_active=0; reset asserted in LAP at count 123 -> next cycle all outputs zero, state IDLE.
